// File: rtl/single_port_ram_pkg.sv
// Shared constants and typedefs for the single-port RAM.
package single_port_ram_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [DATA_W_DEF-1:0] data_t;

endpackage : single_port_ram_pkg

// File: rtl/single_port_ram.sv
// Single-port RAM: flop-based storage, combinational read and
// asynchronous clear of every word.
module single_port_ram
    import single_port_ram_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] ramaddr,
    input  logic [DATA_W-1:0] ramin,
    output logic [DATA_W-1:0] ramout
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // Next contents: unchanged except the addressed word on a write.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[ramaddr] = ramin;
        end
    end

    // Storage; reset clears the whole array without waiting for clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port shows stored contents only, never ramin ahead of the edge.
    assign ramout = mem_q[ramaddr];

endmodule : single_port_ram

// File: tb/tb_single_port_ram.sv
// Self-checking bench for single_port_ram against an array model.
module tb_single_port_ram;
    import single_port_ram_pkg::*;

    localparam int unsigned DEPTH = DEPTH_DEF;

    logic  clk;
    logic  rst_n;
    logic  we;
    addr_t ramaddr;
    data_t ramin;
    data_t ramout;

    data_t model [DEPTH];
    int    n_pass;
    int    n_total;

    single_port_ram dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (we),
        .ramaddr (ramaddr),
        .ramin   (ramin),
        .ramout  (ramout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input data_t got, input data_t exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 8'h%02h expected 8'h%02h (addr %0d, t=%0t)",
                     tag, got, exp, ramaddr, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endtask

    // One write: old value visible before the edge, new value after.
    task automatic write_word(input addr_t a, input data_t d);
        @(negedge clk);
        we = 1'b1; ramaddr = a; ramin = d;
        #1;
        check("rdw_old", ramout, model[a]);
        @(posedge clk);
        model[a] = d;
        #1;
        check("rdw_new", ramout, model[a]);
        we = 1'b0;
    endtask

    task automatic read_word(input addr_t a, input string tag);
        ramaddr = a;
        #1;
        check(tag, ramout, model[a]);
    endtask

    // Async reset pulse between edges, with a write presented during it.
    task automatic reset_pulse(input addr_t a, input data_t d);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        ramaddr = a;
        #1;
        model_clear();
        check("rst_async", ramout, 8'h00);
        we = 1'b1; ramin = d;
        @(posedge clk);
        #1;
        check("rst_wr_lost", ramout, 8'h00);
        we = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_after", ramout, 8'h00);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        we = 1'b0; ramaddr = '0; ramin = '0;
        model_clear();

        // Reset then sweep every address.
        rst_n = 1'b0;
        #1;
        check("rst_hold", ramout, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) read_word(addr_t'(i), "rst_sweep");

        // Single writes and reads.
        write_word(6'd0, 8'hA5);
        @(posedge clk); #1;
        read_word(6'd0, "a5_at_0");
        write_word(6'd10, 8'h3C);
        read_word(6'd10, "3c_at_10");
        read_word(6'd0, "a5_kept");

        // Hold we=0 with data on the bus.
        @(negedge clk);
        ramaddr = 6'd10; ramin = 8'h55; we = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            check("hold_we0", ramout, 8'h3C);
        end

        // Data = address everywhere (back-to-back), then boundary words.
        for (int i = 0; i < int'(DEPTH); i++) write_word(addr_t'(i), data_t'(i));
        for (int i = 0; i < int'(DEPTH); i++) read_word(addr_t'(i), "addr_pattern");
        write_word(6'd63, 8'hFF);
        write_word(6'd0, 8'h00);
        read_word(6'd63, "top_word");
        read_word(6'd62, "top_nbr");
        read_word(6'd0, "bot_word");
        read_word(6'd1, "bot_nbr");

        // Same address repeatedly: last write wins.
        write_word(6'd20, 8'h11);
        write_word(6'd20, 8'h22);
        write_word(6'd20, 8'h33);
        read_word(6'd20, "last_wins");

        // Mid-sequence reset discards everything.
        reset_pulse(6'd10, 8'h77);
        for (int i = 0; i < int'(DEPTH); i++) read_word(addr_t'(i), "post_rst_sweep");
        write_word(6'd5, 8'h9E);
        read_word(6'd5, "first_wr_post_rst");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            op = $urandom_range(0, 99);
            if (op < 50) begin
                write_word(addr_t'($urandom_range(0, DEPTH - 1)), data_t'($urandom));
            end else if (op < 98) begin
                read_word(addr_t'($urandom_range(0, DEPTH - 1)), "rand_read");
            end else begin
                reset_pulse(addr_t'($urandom_range(0, DEPTH - 1)), data_t'($urandom));
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) read_word(addr_t'(i), "final_sweep");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_single_port_ram
